ind_seq_checker: RTL and testbench

Receive-side counterpart of the 3-bit indicator sequence generator. Samples the 3-bit indicator code and decodes it back to the counter value. Checks that successive samples follow the generator's count order and acquires/loses lock with hysteresis. Counts sequence errors. Sits at the far end of the indicator link, feeding status logic.

---
 rtl/ind_seq_checker_if.sv | 24 ++
 rtl/ind_seq_checker.sv | 151 +++++++++++++++
 tb/tb_ind_seq_checker.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/ind_seq_checker_if.sv
// Indicator-link bundle between the sampling side (master) and the sequence
// checker (slave): sample handshake in, decoded status out.
interface ind_seq_checker_if #(
  parameter int unsigned ERR_W = 8
);
  logic             in_valid;
  logic [2:0]       ind_in;
  logic             err_clr;
  logic [2:0]       cnt_out;
  logic             cnt_valid;
  logic             locked;
  logic             err;
  logic [ERR_W-1:0] err_cnt;

  modport master (
    output in_valid, ind_in, err_clr,
    input  cnt_out, cnt_valid, locked, err, err_cnt
  );

  modport slave (
    input  in_valid, ind_in, err_clr,
    output cnt_out, cnt_valid, locked, err, err_cnt
  );
endinterface

// File: rtl/ind_seq_checker.sv
// Receive-side checker for the 3-bit indicator sequence: decodes each sample,
// tracks the expected count, locks/unlocks with hysteresis and counts breaks.
module ind_seq_checker #(
  parameter int unsigned LOCK_N   = 4,
  parameter int unsigned UNLOCK_N = 2,
  parameter int unsigned ERR_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  ind_seq_checker_if.slave bus
);

  localparam int unsigned RUN_W = 4;
  localparam logic [ERR_W-1:0] ERR_MAX = {ERR_W{1'b1}};

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } state_e;

  // Inverse of the generator's code table.
  function automatic logic [2:0] decode(input logic [2:0] code);
    logic [2:0] v;
    case (code)
      3'b000:  v = 3'd0;
      3'b011:  v = 3'd1;
      3'b010:  v = 3'd2;
      3'b101:  v = 3'd3;
      3'b001:  v = 3'd4;
      3'b110:  v = 3'd5;
      3'b100:  v = 3'd6;
      default: v = 3'd7;
    endcase
    return v;
  endfunction

  state_e           state_q, state_d;
  logic [2:0]       exp_q, exp_d;
  logic [RUN_W-1:0] run_q, run_d;
  logic [RUN_W-1:0] miss_q, miss_d;
  logic [2:0]       cnt_q, cnt_d;
  logic             cnt_valid_q, cnt_valid_d;
  logic             locked_q, locked_d;
  logic             err_q, err_d;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
  logic [2:0]       dec_c;
  logic             match_c;
  logic             err_inc_c;

  assign dec_c   = decode(bus.ind_in);
  assign match_c = (dec_c == exp_q);

  // Next-state and output decision.
  always_comb begin
    state_d     = state_q;
    exp_d       = exp_q;
    run_d       = run_q;
    miss_d      = miss_q;
    cnt_d       = cnt_q;
    cnt_valid_d = 1'b0;
    locked_d    = locked_q;
    err_d       = 1'b0;
    err_inc_c   = 1'b0;

    if (bus.in_valid) begin
      cnt_d       = dec_c;
      cnt_valid_d = 1'b1;
      case (state_q)
        HUNT: begin
          exp_d   = dec_c + 3'd1;
          run_d   = RUN_W'(1);
          state_d = VERIFY;
        end
        VERIFY: begin
          if (match_c) begin
            run_d = run_q + RUN_W'(1);
            exp_d = exp_q + 3'd1;
            if ((run_q + RUN_W'(1)) == RUN_W'(LOCK_N)) begin
              state_d  = LOCKED;
              locked_d = 1'b1;
              miss_d   = '0;
            end
          end else begin
            exp_d = dec_c + 3'd1;
            run_d = RUN_W'(1);
          end
        end
        LOCKED: begin
          // Flywheel: expected keeps advancing on a miss instead of re-seeding.
          exp_d = exp_q + 3'd1;
          if (match_c) begin
            miss_d = '0;
          end else begin
            err_d     = 1'b1;
            err_inc_c = 1'b1;
            miss_d    = miss_q + RUN_W'(1);
            if ((miss_q + RUN_W'(1)) == RUN_W'(UNLOCK_N)) begin
              state_d  = HUNT;
              locked_d = 1'b0;
              run_d    = '0;
            end
          end
        end
        default: begin
          state_d  = HUNT;
          locked_d = 1'b0;
        end
      endcase
    end

    // Clear wins over the old count but still records a same-cycle miss.
    err_cnt_d = err_cnt_q;
    if (bus.err_clr) begin
      err_cnt_d = err_inc_c ? ERR_W'(1) : '0;
    end else if (err_inc_c && (err_cnt_q != ERR_MAX)) begin
      err_cnt_d = err_cnt_q + ERR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= HUNT;
      exp_q       <= '0;
      run_q       <= '0;
      miss_q      <= '0;
      cnt_q       <= '0;
      cnt_valid_q <= 1'b0;
      locked_q    <= 1'b0;
      err_q       <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      exp_q       <= exp_d;
      run_q       <= run_d;
      miss_q      <= miss_d;
      cnt_q       <= cnt_d;
      cnt_valid_q <= cnt_valid_d;
      locked_q    <= locked_d;
      err_q       <= err_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign bus.cnt_out   = cnt_q;
  assign bus.cnt_valid = cnt_valid_q;
  assign bus.locked    = locked_q;
  assign bus.err       = err_q;
  assign bus.err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_ind_seq_checker.sv
// Scoreboard bench: dut_a uses default parameters, dut_b (ERR_W=2, UNLOCK_N=15)
// covers counter saturation.
module tb_ind_seq_checker;

  typedef struct packed {
    logic [2:0] cnt;
    logic       lock;
    logic       err;
    logic [7:0] ec;
  } exp_t;

  logic clk;
  logic rst;
  bit   mon_en;
  int   errors;
  int   checks;
  exp_t qa[$];
  exp_t qb[$];

  ind_seq_checker_if #(.ERR_W(8)) ifa ();
  ind_seq_checker_if #(.ERR_W(2)) ifb ();

  ind_seq_checker #(.LOCK_N(4), .UNLOCK_N(2), .ERR_W(8)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (ifa)
  );

  ind_seq_checker #(.LOCK_N(4), .UNLOCK_N(15), .ERR_W(2)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (ifb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  // Monitors: pop one expectation per cnt_valid pulse; err must stay low otherwise.
  always @(negedge clk) begin
    if (mon_en) begin
      if (ifa.cnt_valid) begin
        if (qa.size() == 0) begin
          chk("a_unexpected_valid", 32'(ifa.cnt_out), 32'hdead);
        end else begin
          exp_t e;
          e = qa.pop_front();
          chk("a_cnt_out", 32'(ifa.cnt_out), 32'(e.cnt));
          chk("a_locked",  32'(ifa.locked),  32'(e.lock));
          chk("a_err",     32'(ifa.err),     32'(e.err));
          chk("a_err_cnt", 32'(ifa.err_cnt), 32'(e.ec));
        end
      end else begin
        chk("a_err_idle", 32'(ifa.err), 32'd0);
      end
    end
  end

  always @(negedge clk) begin
    if (mon_en) begin
      if (ifb.cnt_valid) begin
        if (qb.size() == 0) begin
          chk("b_unexpected_valid", 32'(ifb.cnt_out), 32'hdead);
        end else begin
          exp_t e;
          e = qb.pop_front();
          chk("b_cnt_out", 32'(ifb.cnt_out), 32'(e.cnt));
          chk("b_locked",  32'(ifb.locked),  32'(e.lock));
          chk("b_err",     32'(ifb.err),     32'(e.err));
          chk("b_err_cnt", 32'(ifb.err_cnt), 32'(e.ec[1:0]));
        end
      end else begin
        chk("b_err_idle", 32'(ifb.err), 32'd0);
      end
    end
  end

  task automatic send(input bit sel, input logic [2:0] code, input bit clr,
                      input logic [2:0] ecnt, input bit elock, input bit eerr,
                      input logic [7:0] eec);
    exp_t e;
    e.cnt  = ecnt;
    e.lock = elock;
    e.err  = eerr;
    e.ec   = eec;
    @(negedge clk);
    if (sel) begin
      ifa.in_valid = 1'b0; ifa.err_clr = 1'b0;
      ifb.in_valid = 1'b1; ifb.ind_in = code; ifb.err_clr = clr;
      qb.push_back(e);
    end else begin
      ifb.in_valid = 1'b0; ifb.err_clr = 1'b0;
      ifa.in_valid = 1'b1; ifa.ind_in = code; ifa.err_clr = clr;
      qa.push_back(e);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      ifa.in_valid = 1'b0; ifa.err_clr = 1'b0;
      ifb.in_valid = 1'b0; ifb.err_clr = 1'b0;
    end
  endtask

  // Reset with a valid sample on A that must be ignored, then check both DUTs.
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    ifa.in_valid = 1'b1; ifa.ind_in = 3'b111; ifa.err_clr = 1'b0;
    ifb.in_valid = 1'b0; ifb.err_clr = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    ifa.in_valid = 1'b0;
    chk("rst_a_cnt_out",   32'(ifa.cnt_out),   32'd0);
    chk("rst_a_cnt_valid", 32'(ifa.cnt_valid), 32'd0);
    chk("rst_a_locked",    32'(ifa.locked),    32'd0);
    chk("rst_a_err",       32'(ifa.err),       32'd0);
    chk("rst_a_err_cnt",   32'(ifa.err_cnt),   32'd0);
    chk("rst_b_cnt_out",   32'(ifb.cnt_out),   32'd0);
    chk("rst_b_cnt_valid", 32'(ifb.cnt_valid), 32'd0);
    chk("rst_b_locked",    32'(ifb.locked),    32'd0);
    chk("rst_b_err",       32'(ifb.err),       32'd0);
    chk("rst_b_err_cnt",   32'(ifb.err_cnt),   32'd0);
  endtask

  initial begin
    errors = 0;
    checks = 0;
    mon_en = 1'b0;
    rst    = 1'b1;
    ifa.in_valid = 1'b0; ifa.ind_in = 3'b000; ifa.err_clr = 1'b0;
    ifb.in_valid = 1'b0; ifb.ind_in = 3'b000; ifb.err_clr = 1'b0;
    do_reset();
    mon_en = 1'b1;

    // Acquire: 0,1,2,3 -> lock on the 4th sample
    send(0, 3'b000, 0, 3'd0, 0, 0, 8'd0);
    send(0, 3'b011, 0, 3'd1, 0, 0, 8'd0);
    send(0, 3'b010, 0, 3'd2, 0, 0, 8'd0);
    send(0, 3'b101, 0, 3'd3, 1, 0, 8'd0);
    // Wrap through 7 -> 0 while locked
    send(0, 3'b001, 0, 3'd4, 1, 0, 8'd0);
    send(0, 3'b110, 0, 3'd5, 1, 0, 8'd0);
    send(0, 3'b100, 0, 3'd6, 1, 0, 8'd0);
    send(0, 3'b111, 0, 3'd7, 1, 0, 8'd0);
    send(0, 3'b000, 0, 3'd0, 1, 0, 8'd0);
    send(0, 3'b011, 0, 3'd1, 1, 0, 8'd0);
    // Lock loss at expected=2 after two misses, then re-acquire
    send(0, 3'b111, 0, 3'd7, 1, 1, 8'd1);
    send(0, 3'b111, 0, 3'd7, 0, 1, 8'd2);
    send(0, 3'b000, 0, 3'd0, 0, 0, 8'd2);
    send(0, 3'b011, 0, 3'd1, 0, 0, 8'd2);
    send(0, 3'b010, 0, 3'd2, 0, 0, 8'd2);
    send(0, 3'b101, 0, 3'd3, 1, 0, 8'd2);
    // Single glitch at expected=4: flywheel makes the repeat a match
    send(0, 3'b110, 0, 3'd5, 1, 1, 8'd3);
    send(0, 3'b110, 0, 3'd5, 1, 0, 8'd3);
    // Gaps keep lock and state
    send(0, 3'b100, 0, 3'd6, 1, 0, 8'd3);
    idle(3);
    chk("gap_locked", 32'(ifa.locked), 32'd1);
    send(0, 3'b111, 0, 3'd7, 1, 0, 8'd3);
    idle(3);
    chk("gap_locked2", 32'(ifa.locked), 32'd1);
    send(0, 3'b000, 0, 3'd0, 1, 0, 8'd3);
    // Build err_cnt to 5 without losing lock
    send(0, 3'b000, 0, 3'd0, 1, 1, 8'd4);
    send(0, 3'b010, 0, 3'd2, 1, 0, 8'd4);
    send(0, 3'b000, 0, 3'd0, 1, 1, 8'd5);
    @(negedge clk);
    ifa.in_valid = 1'b0; ifa.err_clr = 1'b1;
    @(negedge clk);
    ifa.err_clr = 1'b0;
    chk("clr_err_cnt", 32'(ifa.err_cnt), 32'd0);
    chk("clr_locked",  32'(ifa.locked),  32'd1);
    // Clear coincident with a counted mismatch
    send(0, 3'b001, 0, 3'd4, 1, 0, 8'd0);
    send(0, 3'b000, 1, 3'd0, 1, 1, 8'd1);
    send(0, 3'b100, 0, 3'd6, 1, 0, 8'd1);
    // Reset mid-lock, then fresh re-acquire from an arbitrary start
    do_reset();
    send(0, 3'b100, 0, 3'd6, 0, 0, 8'd0);
    send(0, 3'b111, 0, 3'd7, 0, 0, 8'd0);
    send(0, 3'b000, 0, 3'd0, 0, 0, 8'd0);
    send(0, 3'b011, 0, 3'd1, 1, 0, 8'd0);
    idle(2);

    // Saturation on the 2-bit counter
    send(1, 3'b000, 0, 3'd0, 0, 0, 8'd0);
    send(1, 3'b011, 0, 3'd1, 0, 0, 8'd0);
    send(1, 3'b010, 0, 3'd2, 0, 0, 8'd0);
    send(1, 3'b101, 0, 3'd3, 1, 0, 8'd0);
    send(1, 3'b011, 0, 3'd1, 1, 1, 8'd1);
    send(1, 3'b011, 0, 3'd1, 1, 1, 8'd2);
    send(1, 3'b011, 0, 3'd1, 1, 1, 8'd3);
    send(1, 3'b011, 0, 3'd1, 1, 1, 8'd3);
    send(1, 3'b011, 0, 3'd1, 1, 1, 8'd3);
    idle(1);
    do_reset();
    idle(2);

    chk("a_queue_drained", 32'(qa.size()), 32'd0);
    chk("b_queue_drained", 32'(qb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
